affine_cand_sched: RTL

Sequencer that runs the affine motion-estimation engine (`affine`) over a list of up to MAX_CAND control-point-MV candidates for one prediction unit. It reads each candidate from an external candidate memory and drives the engine's `start_load`/`start_calc` handshake and MV inputs. It tracks the minimum RD cost against the HEVC (translational) cost and reports the winning candidate, its cost and its mode. It sits between the CU-level ME controller and the affine engine.

---
 rtl/affine_cand_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/affine_cand_sched.sv
// affine_cand_sched: walks a list of control-point MV candidates through the
// affine motion-estimation engine and keeps the cheapest result, using the
// translational (HEVC) cost as the initial best.
//
// Handshake: `start` is a one-cycle request accepted only in IDLE; `done` is a
// one-cycle completion pulse and `busy` covers every cycle from the accepted
// start through the done cycle. Engine side: `eng_start_load` and
// `eng_start_calc` are single-cycle pulses. `eng_done` is a single-cycle
// response whose `eng_cost`/`eng_mode` are valid only in that cycle. It is
// honoured only while waiting on the engine. Candidate memory returns
// `cand_mv` exactly one cycle after `cand_rd_en`.
module affine_cand_sched #(
  parameter int MAX_CAND = 8,
  parameter int IDX_W    = 4,
  parameter int TIMEOUT  = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   num_cand,
  input  logic [20:0]        rdcost_HEVC,
  output logic               cand_rd_en,
  output logic [IDX_W-1:0]   cand_rd_addr,
  input  logic [77:0]        cand_mv,
  output logic               eng_start_load,
  output logic               eng_start_calc,
  output logic signed [12:0] eng_mvLT_x,
  output logic signed [12:0] eng_mvLT_y,
  output logic signed [12:0] eng_mvRT_x,
  output logic signed [12:0] eng_mvRT_y,
  output logic signed [12:0] eng_mvLB_x,
  output logic signed [12:0] eng_mvLB_y,
  input  logic               eng_done,
  input  logic [20:0]        eng_cost,
  input  logic [2:0]         eng_mode,
  output logic               busy,
  output logic               done,
  output logic [20:0]        best_cost,
  output logic [IDX_W-1:0]   best_idx,
  output logic [2:0]         best_mode,
  output logic               use_affine,
  output logic               timeout_err,
  output logic [3:0]         dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CAPT, S_LOAD, S_GAP, S_CALC, S_WAIT, S_CMP, S_FINISH
  } state_t;

  localparam logic [IDX_W-1:0] MAX_C   = IDX_W'(MAX_CAND);
  localparam logic [11:0]      WD_LAST = 12'(TIMEOUT - 1);
  localparam logic [11:0]      WD_MAX  = 12'hFFF;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  last_q;
  logic [11:0]       wd_q;
  logic [20:0]       lat_cost_q;
  logic [2:0]        lat_mode_q;
  logic              lat_ok_q;
  logic              rd_en_q;
  logic [IDX_W-1:0]  rd_addr_q;
  logic              load_q;
  logic              calc_q;
  logic [77:0]       mv_q;
  logic              busy_q;
  logic              done_q;
  logic [20:0]       best_cost_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [2:0]        best_mode_q;
  logic              use_aff_q;
  logic              tmo_q;
  logic [IDX_W-1:0]  num_clamp_d;

  // Clamp the requested candidate count to the supported maximum.
  always_comb begin
    num_clamp_d = (num_cand > MAX_C) ? MAX_C : num_cand;
  end

  // Sequencer: one registered FSM owning every output and bookkeeping register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      wd_q        <= '0;
      lat_cost_q  <= '0;
      lat_mode_q  <= '0;
      lat_ok_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      load_q      <= 1'b0;
      calc_q      <= 1'b0;
      mv_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_cost_q <= '0;
      best_idx_q  <= '0;
      best_mode_q <= '0;
      use_aff_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      load_q  <= 1'b0;
      calc_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            best_cost_q <= rdcost_HEVC;
            best_idx_q  <= '0;
            best_mode_q <= '0;
            use_aff_q   <= 1'b0;
            tmo_q       <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            last_q      <= num_clamp_d - 1'b1;
            if (num_clamp_d == '0) begin
              state_q <= S_FINISH;
            end else begin
              state_q   <= S_FETCH;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
            end
          end
        end
        S_FETCH: state_q <= S_CAPT;
        S_CAPT: begin
          mv_q    <= cand_mv;
          load_q  <= 1'b1;
          state_q <= S_LOAD;
        end
        S_LOAD: state_q <= S_GAP;
        S_GAP: begin
          calc_q  <= 1'b1;
          state_q <= S_CALC;
        end
        S_CALC: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            lat_cost_q <= eng_cost;
            lat_mode_q <= eng_mode;
            lat_ok_q   <= 1'b1;
            state_q    <= S_CMP;
          end else if (wd_q == WD_LAST) begin
            // Engine never answered: flag it and let CMP skip this candidate.
            tmo_q    <= 1'b1;
            lat_ok_q <= 1'b0;
            state_q  <= S_CMP;
          end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + 12'd1;
          end
        end
        S_CMP: begin
          // Strict less-than: ties keep the earlier winner, HEVC included.
          if (lat_ok_q && (lat_cost_q < best_cost_q)) begin
            best_cost_q <= lat_cost_q;
            best_idx_q  <= idx_q;
            best_mode_q <= lat_mode_q;
            use_aff_q   <= 1'b1;
          end
          if (idx_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            idx_q     <= idx_q + 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= idx_q + 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FINISH: begin
          // An empty run enters FINISH straight from IDLE without done set,
          // so it spends one extra cycle here before pulsing done.
          if (done_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cand_rd_en     = rd_en_q;
  assign cand_rd_addr   = rd_addr_q;
  assign eng_start_load = load_q;
  assign eng_start_calc = calc_q;
  assign eng_mvLT_x     = mv_q[77:65];
  assign eng_mvLT_y     = mv_q[64:52];
  assign eng_mvRT_x     = mv_q[51:39];
  assign eng_mvRT_y     = mv_q[38:26];
  assign eng_mvLB_x     = mv_q[25:13];
  assign eng_mvLB_y     = mv_q[12:0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign best_cost      = best_cost_q;
  assign best_idx       = best_idx_q;
  assign best_mode      = best_mode_q;
  assign use_affine     = use_aff_q;
  assign timeout_err    = tmo_q;
  assign dbg_state      = state_q;

endmodule
